// File: rtl/ppfifo_mc_pkg.sv
// Shared FSM state types and width helpers for the multi-channel ping-pong FIFO.
package ppfifo_mc_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rd_state_t;

  function automatic int chan_width(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ppfifo_mc_if.sv
// Producer/consumer port bundle for ppfifo_mc; PPFIFO_MC_LEVEL_EN adds the
// per-channel level and almost_full outputs (and the DEPTH parameter they need).
interface ppfifo_mc_if
  import ppfifo_mc_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = 8,
  parameter int CHANNELS       = 2
`ifdef PPFIFO_MC_LEVEL_EN
  , parameter int DEPTH        = 4
`endif
);

  localparam int CHAN_W = chan_width(CHANNELS);

  logic                      put_req;
  logic [CHAN_W-1:0]         put_chan;
  logic [FIFO_WORD_SIZE-1:0] put_value;
  logic                      put_ack;
  logic                      get_req;
  logic [CHAN_W-1:0]         get_chan;
  logic [FIFO_WORD_SIZE-1:0] get_value;
  logic                      get_ack;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       empty;
  logic                      chan_err;
`ifdef PPFIFO_MC_LEVEL_EN
  localparam int LVL_W = level_width(DEPTH);
  logic [LVL_W-1:0]          level [CHANNELS];
  logic [CHANNELS-1:0]       almost_full;
`endif

  modport master (
    output put_req, put_chan, put_value,
    input  put_ack,
    output get_req, get_chan,
    input  get_value, get_ack, full, empty, chan_err
`ifdef PPFIFO_MC_LEVEL_EN
    , input level, almost_full
`endif
  );

  modport slave (
    input  put_req, put_chan, put_value,
    output put_ack,
    input  get_req, get_chan,
    output get_value, get_ack, full, empty, chan_err
`ifdef PPFIFO_MC_LEVEL_EN
    , output level, almost_full
`endif
  );

endinterface

// File: rtl/ppfifo_mc_channel.sv
// One circular queue of DEPTH words with registered full/empty flags;
// PPFIFO_MC_LEVEL_EN exposes the word count and an almost-full flag.
module ppfifo_mc_channel
  import ppfifo_mc_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = 8,
  parameter int DEPTH          = 4,
  localparam int LVL_W         = level_width(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [FIFO_WORD_SIZE-1:0] wr_data,
  input  logic                      rd_en,
  output logic [FIFO_WORD_SIZE-1:0] rd_data,
  output logic                      full,
  output logic                      empty
`ifdef PPFIFO_MC_LEVEL_EN
  , output logic [LVL_W-1:0]        level
  , output logic                    almost_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ZERO_L  = {LVL_W{1'b0}};

  logic [FIFO_WORD_SIZE-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r, wr_ptr_nxt_s;
  logic [PTR_W-1:0]          rd_ptr_r, rd_ptr_nxt_s;
  logic [LVL_W-1:0]          count_r, count_nxt_s;
  logic                      full_r, empty_r;

  // Pointer/count next state; clear wins over any push or pop in its cycle.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (clear) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = ZERO_L;
    end else begin
      if (wr_en) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (rd_en) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({wr_en, rd_en})
        2'b10:   count_nxt_s = count_r + LVL_W'(1'b1);
        2'b01:   count_nxt_s = count_r - LVL_W'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_L;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_L);
      empty_r  <= (count_nxt_s == ZERO_L);
    end
  end

  // Storage carries no reset; reads are only taken from occupied slots.
  always_ff @(posedge clock) begin
    if (wr_en && !clear) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;

`ifdef PPFIFO_MC_LEVEL_EN
  localparam logic [LVL_W-1:0] AFULL_L = LVL_W'(DEPTH - 1);
  logic almost_full_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      almost_full_r <= 1'b0;
    end else begin
      almost_full_r <= (count_nxt_s >= AFULL_L);
    end
  end

  assign level       = count_r;
  assign almost_full = almost_full_r;
`endif

endmodule

// File: rtl/ppfifo_mc.sv
// Multi-channel four-phase req/ack FIFO: write/read FSMs, channel decode and
// registered read data. Optional outputs are enabled by PPFIFO_MC_LEVEL_EN.
module ppfifo_mc
  import ppfifo_mc_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = 8,
  parameter int DEPTH          = 4,
  parameter int CHANNELS       = 2
) (
  input logic          clock,
  input logic          reset,
  input logic          clear,
  ppfifo_mc_if.slave   bus
);

  localparam int CHAN_W = chan_width(CHANNELS);
  localparam logic [CHAN_W:0] CHAN_LIM = (CHAN_W + 1)'(CHANNELS);

  wr_state_t                 wr_state_r, wr_state_nxt_s;
  rd_state_t                 rd_state_r, rd_state_nxt_s;
  logic                      put_ack_r, get_ack_r;
  logic                      put_accept_s, get_accept_s;
  logic                      put_ok_s, get_ok_s;
  logic [FIFO_WORD_SIZE-1:0] get_value_r;
  logic                      chan_err_r;
  logic [CHANNELS-1:0]       full_s, empty_s;
  logic [CHANNELS-1:0]       wr_en_s, rd_en_s;
  logic [FIFO_WORD_SIZE-1:0] rd_data_s [CHANNELS];

  assign put_ok_s = ({1'b0, bus.put_chan} < CHAN_LIM);
  assign get_ok_s = ({1'b0, bus.get_chan} < CHAN_LIM);

  // Write handshake: one word per req/ack cycle, gated by the registered full flag.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    put_accept_s   = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (bus.put_req && put_ok_s && !full_s[bus.put_chan] && !clear) begin
          put_accept_s   = 1'b1;
          wr_state_nxt_s = W_ACK;
        end else begin
          wr_state_nxt_s = W_IDLE;
        end
      end
      W_ACK: begin
        if (!bus.put_req) begin
          wr_state_nxt_s = W_IDLE;
        end else begin
          wr_state_nxt_s = W_ACK;
        end
      end
      default: wr_state_nxt_s = W_IDLE;
    endcase
  end

  // Read handshake: registered empty flag means a same-cycle write cannot fall through.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    get_accept_s   = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (bus.get_req && get_ok_s && !empty_s[bus.get_chan] && !clear) begin
          get_accept_s   = 1'b1;
          rd_state_nxt_s = R_ACK;
        end else begin
          rd_state_nxt_s = R_IDLE;
        end
      end
      R_ACK: begin
        if (!bus.get_req) begin
          rd_state_nxt_s = R_IDLE;
        end else begin
          rd_state_nxt_s = R_ACK;
        end
      end
      default: rd_state_nxt_s = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_r  <= W_IDLE;
      rd_state_r  <= R_IDLE;
      put_ack_r   <= 1'b0;
      get_ack_r   <= 1'b0;
      get_value_r <= {FIFO_WORD_SIZE{1'b0}};
      chan_err_r  <= 1'b0;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      rd_state_r <= rd_state_nxt_s;
      put_ack_r  <= (wr_state_nxt_s == W_ACK);
      get_ack_r  <= (rd_state_nxt_s == R_ACK);
      if (get_accept_s) begin
        get_value_r <= rd_data_s[bus.get_chan];
      end else begin
        get_value_r <= get_value_r;
      end
      if ((bus.put_req && !put_ok_s) || (bus.get_req && !get_ok_s)) begin
        chan_err_r <= 1'b1;
      end else begin
        chan_err_r <= chan_err_r;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign wr_en_s[c] = put_accept_s && (bus.put_chan == CHAN_W'(c));
    assign rd_en_s[c] = get_accept_s && (bus.get_chan == CHAN_W'(c));

    ppfifo_mc_channel #(
      .FIFO_WORD_SIZE (FIFO_WORD_SIZE),
      .DEPTH          (DEPTH)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .wr_en       (wr_en_s[c]),
      .wr_data     (bus.put_value),
      .rd_en       (rd_en_s[c]),
      .rd_data     (rd_data_s[c]),
      .full        (full_s[c]),
      .empty       (empty_s[c])
`ifdef PPFIFO_MC_LEVEL_EN
      , .level       (bus.level[c])
      , .almost_full (bus.almost_full[c])
`endif
    );
  end

  assign bus.put_ack   = put_ack_r;
  assign bus.get_ack   = get_ack_r;
  assign bus.get_value = get_value_r;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.chan_err  = chan_err_r;

endmodule

// File: tb/tb_ppfifo_mc.sv
// Directed bench for ppfifo_mc: a 2-channel instance for data-path checks and a
// 3-channel instance for out-of-range channel detection.
module tb_ppfifo_mc;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  ppfifo_mc_if #(.FIFO_WORD_SIZE(8), .CHANNELS(2)
`ifdef PPFIFO_MC_LEVEL_EN
    , .DEPTH(4)
`endif
  ) bus ();

  ppfifo_mc_if #(.FIFO_WORD_SIZE(8), .CHANNELS(3)
`ifdef PPFIFO_MC_LEVEL_EN
    , .DEPTH(4)
`endif
  ) bus3 ();

  ppfifo_mc #(.FIFO_WORD_SIZE(8), .DEPTH(4), .CHANNELS(2)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  ppfifo_mc #(.FIFO_WORD_SIZE(8), .DEPTH(4), .CHANNELS(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_put(input logic ch, input logic [7:0] val, input int hold);
    bus.put_chan  = ch;
    bus.put_value = val;
    bus.put_req   = 1'b1;
    for (int i = 0; i < 12 && bus.put_ack !== 1'b1; i++) tick();
    check("put_ack_rise", bus.put_ack, 32'd1);
    repeat (hold) tick();
    check("put_ack_hold", bus.put_ack, 32'd1);
    bus.put_req = 1'b0;
    tick();
    check("put_ack_drop", bus.put_ack, 32'd0);
  endtask

  task automatic do_get(input logic ch, input logic [7:0] exp, input int hold);
    bus.get_chan = ch;
    bus.get_req  = 1'b1;
    for (int i = 0; i < 12 && bus.get_ack !== 1'b1; i++) tick();
    check("get_ack_rise", bus.get_ack, 32'd1);
    check("get_value", bus.get_value, {24'd0, exp});
    repeat (hold) tick();
    check("get_ack_hold", bus.get_ack, 32'd1);
    bus.get_req = 1'b0;
    tick();
    check("get_ack_drop", bus.get_ack, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.put_req = 1'b0;  bus.put_chan = 1'b0;  bus.put_value = 8'h00;
    bus.get_req = 1'b0;  bus.get_chan = 1'b0;
    bus3.put_req = 1'b0; bus3.put_chan = 2'd0; bus3.put_value = 8'h00;
    bus3.get_req = 1'b0; bus3.get_chan = 2'd0;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_put_ack", bus.put_ack, 32'd0);
    check("rst_get_ack", bus.get_ack, 32'd0);
    check("rst_get_value", bus.get_value, 32'h00);
    check("rst_empty", bus.empty, 32'b11);
    check("rst_full", bus.full, 32'b00);
    check("rst_chan_err", bus.chan_err, 32'd0);

    // Interleaved channels keep independent order
    do_put(1'b0, 8'hA1, 0);
    do_put(1'b0, 8'hA2, 2);
    do_put(1'b1, 8'hB1, 1);
    check("two_chan_empty", bus.empty, 32'b00);
    do_get(1'b1, 8'hB1, 2);
    do_get(1'b0, 8'hA1, 0);
    do_get(1'b0, 8'hA2, 1);
    check("drained_empty", bus.empty, 32'b11);

    // Fill ch0, block a fifth put, release it with one pop
    do_put(1'b0, 8'h10, 0);
    do_put(1'b0, 8'h11, 0);
    do_put(1'b0, 8'h12, 0);
    do_put(1'b0, 8'h13, 0);
    check("full_flag", bus.full, 32'b01);
    check("full_empty_flags", bus.empty, 32'b10);
    bus.put_chan  = 1'b0;
    bus.put_value = 8'h14;
    bus.put_req   = 1'b1;
    repeat (3) tick();
    check("full_blocks_put", bus.put_ack, 32'd0);
    bus.get_chan = 1'b0;
    bus.get_req  = 1'b1;
    tick();
    check("pop_ack", bus.get_ack, 32'd1);
    check("pop_value", bus.get_value, 32'h10);
    check("put_waits_reg_full", bus.put_ack, 32'd0);
    check("full_after_pop", bus.full, 32'b00);
    bus.get_req = 1'b0;
    tick();
    check("put_after_pop", bus.put_ack, 32'd1);
    check("pop_ack_drop", bus.get_ack, 32'd0);
    check("refull_flag", bus.full, 32'b01);
    bus.put_req = 1'b0;
    tick();
    check("put_ack_drop5", bus.put_ack, 32'd0);
    do_get(1'b0, 8'h11, 0);
    do_get(1'b0, 8'h12, 0);
    do_get(1'b0, 8'h13, 0);
    do_get(1'b0, 8'h14, 0);
    check("wrap_empty", bus.empty, 32'b11);

    // Long-held put stores exactly one word
    do_put(1'b0, 8'h55, 5);
`ifdef PPFIFO_MC_LEVEL_EN
    check("level_one", bus.level[0], 32'd1);
    check("almost_full_low", bus.almost_full, 32'b00);
`endif
    do_get(1'b0, 8'h55, 0);
    check("one_word_empty", bus.empty, 32'b11);
    bus.get_chan = 1'b0;
    bus.get_req  = 1'b1;
    repeat (3) tick();
    check("empty_blocks_get", bus.get_ack, 32'd0);
    bus.get_req = 1'b0;
    tick();

    // clear flushes and overrides a same-cycle put
    do_put(1'b1, 8'h21, 0);
    do_put(1'b1, 8'h22, 0);
    check("pre_clear_empty", bus.empty, 32'b01);
    clear         = 1'b1;
    bus.put_chan  = 1'b0;
    bus.put_value = 8'h66;
    bus.put_req   = 1'b1;
    tick();
    check("clear_empty", bus.empty, 32'b11);
    check("clear_blocks_put", bus.put_ack, 32'd0);
    check("clear_keeps_value", bus.get_value, 32'h55);
    clear = 1'b0;
    tick();
    check("put_after_clear", bus.put_ack, 32'd1);
    check("post_clear_empty", bus.empty, 32'b10);
    bus.put_req = 1'b0;
    tick();
    check("put_ack_drop_clr", bus.put_ack, 32'd0);
    do_get(1'b0, 8'h66, 0);

    // Out-of-range channel on the 3-channel instance
    bus3.put_chan  = 2'd3;
    bus3.put_value = 8'h77;
    bus3.put_req   = 1'b1;
    repeat (2) tick();
    check("oor_no_ack", bus3.put_ack, 32'd0);
    check("oor_chan_err", bus3.chan_err, 32'd1);
    check("oor_no_state", bus3.empty, 32'b111);
    bus3.put_req = 1'b0;
    repeat (2) tick();
    check("chan_err_sticky", bus3.chan_err, 32'd1);
    check("chan_err_isolated", bus.chan_err, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("chan_err_reset", bus3.chan_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
